inst_fetch_resp: RTL and testbench
==================================

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 SHALL have parameter AddrLen, default 32, byte-address width of fetch requests and RAM address.
REQ-002 SHALL have parameter InstLen, default 32, width of the returned instruction word.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rdy, input, 1, global ready; when low, all state freezes.
REQ-006 SHALL have port req_valid, input, 1, fetch request from the PC stage is present.
REQ-007 SHALL have port req_pc, input, AddrLen, byte address of the instruction to fetch.
REQ-008 SHALL have port req_ready, output, 1, block can accept a request.
REQ-009 SHALL have port flush, input, 1, discard any in-flight fetch (branch/jump redirect).
REQ-010 SHALL have port resp_valid, output, 1, resp_inst holds a complete instruction.
REQ-011 SHALL have port resp_inst, output, InstLen, fetched instruction, little-endian assembled.
REQ-012 SHALL have port resp_pc, output, AddrLen, address the response belongs to.
REQ-013 SHALL have port resp_ready, input, 1, consumer accepts the response.
REQ-014 SHALL have port mem_a, output, AddrLen, byte address to the RAM, registered.
REQ-015 SHALL have port mem_din, input, 8, RAM read byte; valid in the cycle after its address is driven.
REQ-016 SHALL have port mem_wr, output, 1, RAM write enable; tied to 0 (read-only responder).

Function
REQ-017 SHALL implement states IDLE, FETCH, RESP.
REQ-018 In IDLE, req_ready SHALL be 1; elsewhere 0.
REQ-019 A request SHALL be accepted at a rising edge with rdy=1, req_valid=1, req_ready=1, flush=0; req_pc is latched and the state moves to FETCH.
REQ-020 In FETCH, mem_a SHALL step through latched pc+0, pc+1, pc+2, pc+3 on four consecutive active edges, starting with the acceptance edge.
REQ-021 The byte at mem_a=pc+i SHALL be captured from mem_din on the following active edge into resp_inst bits [8i+7:8i].
REQ-022 Address arithmetic SHALL be modulo 2^AddrLen (0xFFFFFFFF+1 wraps to 0x00000000).
REQ-023 resp_valid SHALL rise on the fifth active edge after acceptance (the edge capturing byte 3), with the state moving to RESP.
REQ-024 In RESP, resp_valid, resp_inst and resp_pc SHALL hold stable until an active edge with resp_ready=1, then the state returns to IDLE with resp_valid=0.
REQ-025 No new request SHALL be accepted in the same edge a response completes; minimum request-to-request spacing is 6 active edges.
REQ-026 flush=1 at an active edge SHALL force IDLE and resp_valid=0 in any state, including in the acceptance cycle; it discards the fetch with no response. It takes priority over req_valid and resp_ready.
REQ-027 With rdy=0, state, mem_a, byte counter and outputs SHALL hold. The RAM is frozen under the same rdy, so mem_din remains valid for the held address.
REQ-028 Outside FETCH, mem_a SHALL hold its last value; mem_wr SHALL be 0 always.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force IDLE, req_ready=1 (in IDLE), resp_valid=0, resp_inst=0, resp_pc=0, mem_a=0, byte counter=0, mem_wr=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the fetch with no response; first acceptance is possible on the first active edge after rst returns to 1.

Verification
REQ-031 Basic: req_pc=0x00001000, RAM bytes 0x13,0x05,0x10,0x00 at 0x1000..0x1003, resp_ready=1 -> resp_valid at 5th edge after acceptance, resp_inst=0x00100513, resp_pc=0x1000, back in IDLE the next edge.
REQ-032 Backpressure: same as REQ-031 with resp_ready=0 for 3 cycles -> resp_valid and data held unchanged for 3 cycles; req_ready=0 throughout; release on the edge after resp_ready=1.
REQ-033 Stall: rdy=0 for 2 cycles after byte 1 is captured -> mem_a frozen, completion delayed exactly 2 cycles, resp_inst still correct.
REQ-034 Flush: flush=1 on the 3rd FETCH edge -> IDLE next edge, no resp_valid pulse; new req_pc=0x2000 accepted the edge after and returns the correct word.
REQ-035 Wrap: req_pc=0xFFFFFFFE -> mem_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; bytes assembled in that order.
REQ-036 Async reset: drop rst between clock edges during FETCH -> resp_valid=0, mem_a=0 before the next edge; no response afterwards.

Source files
------------

// File: rtl/inst_fetch_resp_if.sv
// Fetch-responder bus: PC-stage request, consumer response and byte RAM port.
`timescale 1ns/1ps
interface inst_fetch_resp_if #(
  parameter int AddrLen = 32,
  parameter int InstLen = 32
);
  logic               req_valid;
  logic [AddrLen-1:0] req_pc;
  logic               req_ready;
  logic               resp_valid;
  logic [InstLen-1:0] resp_inst;
  logic [AddrLen-1:0] resp_pc;
  logic               resp_ready;
  logic [AddrLen-1:0] mem_a;
  logic [7:0]         mem_din;
  logic               mem_wr;

  // Requester / consumer / RAM side
  modport master (
    output req_valid, req_pc, resp_ready, mem_din,
    input  req_ready, resp_valid, resp_inst, resp_pc, mem_a, mem_wr
  );

  // Fetch responder side
  modport slave (
    input  req_valid, req_pc, resp_ready, mem_din,
    output req_ready, resp_valid, resp_inst, resp_pc, mem_a, mem_wr
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: reads four bytes from a byte-wide RAM and
// returns them as one little-endian instruction word with a valid/ready handshake.
`timescale 1ns/1ps
module inst_fetch_resp #(
  parameter int AddrLen = 32,
  parameter int InstLen = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  inst_fetch_resp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         cnt_r;
  logic [1:0]         cnt_nxt_s;
  logic [AddrLen-1:0] pc_r;
  logic [AddrLen-1:0] pc_nxt_s;
  logic [AddrLen-1:0] mem_a_r;
  logic [AddrLen-1:0] mem_a_nxt_s;
  logic [AddrLen-1:0] resp_pc_r;
  logic [AddrLen-1:0] resp_pc_nxt_s;
  logic [InstLen-1:0] inst_r;
  logic [InstLen-1:0] inst_nxt_s;
  logic               resp_valid_r;
  logic               resp_valid_nxt_s;
  logic               req_ready_r;
  logic               req_ready_nxt_s;

  // State register; rdy low freezes the machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else if (rdy) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (bus.req_valid) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == 2'd3) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      RESP: begin
        if (flush || bus.resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath/output next values: address stepping, byte capture, response handshake
  always_comb begin
    pc_nxt_s         = pc_r;
    mem_a_nxt_s      = mem_a_r;
    cnt_nxt_s        = cnt_r;
    inst_nxt_s       = inst_r;
    resp_pc_nxt_s    = resp_pc_r;
    resp_valid_nxt_s = resp_valid_r;
    req_ready_nxt_s  = (state_nxt_s == IDLE);
    if (flush) begin
      resp_valid_nxt_s = 1'b0;
      cnt_nxt_s        = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            // byte 0 address goes out on the acceptance edge itself
            pc_nxt_s    = bus.req_pc;
            mem_a_nxt_s = bus.req_pc;
            cnt_nxt_s   = 2'd0;
          end else begin
            cnt_nxt_s   = 2'd0;
          end
        end
        FETCH: begin
          // mem_din belongs to the address presented during this cycle
          inst_nxt_s[{cnt_r, 3'b000} +: 8] = bus.mem_din;
          if (cnt_r == 2'd3) begin
            resp_valid_nxt_s = 1'b1;
            resp_pc_nxt_s    = pc_r;
            cnt_nxt_s        = 2'd0;
          end else begin
            cnt_nxt_s   = cnt_r + 2'd1;
            // plain modular add gives the 2^AddrLen wrap
            mem_a_nxt_s = pc_r + AddrLen'(cnt_r + 2'd1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_nxt_s = 1'b0;
          end else begin
            resp_valid_nxt_s = 1'b1;
          end
        end
        default: begin
          resp_valid_nxt_s = 1'b0;
          cnt_nxt_s        = 2'd0;
        end
      endcase
    end
  end

  // Datapath and output registers, held while rdy is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r         <= {AddrLen{1'b0}};
      mem_a_r      <= {AddrLen{1'b0}};
      cnt_r        <= 2'd0;
      inst_r       <= {InstLen{1'b0}};
      resp_pc_r    <= {AddrLen{1'b0}};
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
    end else if (rdy) begin
      pc_r         <= pc_nxt_s;
      mem_a_r      <= mem_a_nxt_s;
      cnt_r        <= cnt_nxt_s;
      inst_r       <= inst_nxt_s;
      resp_pc_r    <= resp_pc_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      req_ready_r  <= req_ready_nxt_s;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_inst  = inst_r;
  assign bus.resp_pc    = resp_pc_r;
  assign bus.mem_a      = mem_a_r;
  assign bus.mem_wr     = 1'b0;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_inst_fetch_resp;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;

  inst_fetch_resp_if #(.AddrLen(32), .InstLen(32)) bus ();

  inst_fetch_resp #(.AddrLen(32), .InstLen(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM contents: a fixed program word at 0x1000, address hash elsewhere
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  // Byte-wide RAM: data for the presented address is available in the same cycle
  assign bus.mem_din = mb(bus.mem_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  int          m_k     = 0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_word  = 32'h0;
  logic [31:0] m_rword = 32'h0;
  logic [31:0] m_rpc   = 32'h0;

  // Model: a fetch takes four edges after acceptance, then waits for the consumer
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_k     <= 0;
      m_addr  <= 32'h0;
      m_rword <= 32'h0;
      m_rpc   <= 32'h0;
    end else if (rdy) begin
      if (flush) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end else if (m_valid) begin
        if (bus.resp_ready) m_valid <= 1'b0;
      end else if (m_busy) begin
        if (m_k < 3) begin
          m_k    <= m_k + 1;
          m_addr <= m_pc + 32'(m_k + 1);
        end else begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_rword <= m_word;
          m_rpc   <= m_pc;
        end
      end else if (bus.req_valid) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_pc   <= bus.req_pc;
        m_addr <= bus.req_pc;
        m_word <= {mb(bus.req_pc + 32'd3), mb(bus.req_pc + 32'd2),
                   mb(bus.req_pc + 32'd1), mb(bus.req_pc)};
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("req_ready",  {31'd0, bus.req_ready},  {31'd0, !m_busy && !m_valid});
    chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, m_valid});
    chk("mem_a",      bus.mem_a, m_addr);
    chk("mem_wr",     {31'd0, bus.mem_wr}, 32'd0);
    if (m_valid) begin
      chk("resp_inst", bus.resp_inst, m_rword);
      chk("resp_pc",   bus.resp_pc,   m_rpc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count edges until resp_valid shows, bounded
  task automatic wait_resp(input int start, output int n);
    n = start;
    while (!bus.resp_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic accept(input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    tick();
    bus.req_valid = 1'b0;
  endtask

  logic [31:0] wrap_a [4];

  initial begin
    wrap_a[0] = 32'hFFFF_FFFE;
    wrap_a[1] = 32'hFFFF_FFFF;
    wrap_a[2] = 32'h0000_0000;
    wrap_a[3] = 32'h0000_0001;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_pc = 32'h0; bus.resp_ready = 1'b1;
    tick(); tick();
    chk("rst_resp_inst", bus.resp_inst, 32'h0);
    chk("rst_resp_pc",   bus.resp_pc,   32'h0);
    chk("rst_mem_a",     bus.mem_a,     32'h0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    rst = 1'b1;
    tick();

    // basic fetch
    accept(32'h0000_1000);
    wait_resp(1, lat);
    chk("basic_lat",  lat, 32'd5);
    chk("basic_inst", bus.resp_inst, 32'h0010_0513);
    chk("basic_pc",   bus.resp_pc,   32'h0000_1000);
    tick();
    chk("basic_idle", {31'd0, bus.req_ready}, 32'd1);

    // backpressure, with a pending request waiting behind the response
    bus.resp_ready = 1'b0;
    accept(32'h0000_1000);
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h0000_2000;
    wait_resp(1, lat);
    chk("bp_lat", lat, 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_hold_inst",  bus.resp_inst, 32'h0010_0513);
      chk("bp_req_ready",  {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_release",  {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_no_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    chk("bp_next_accept", {31'd0, bus.req_ready}, 32'd0);
    bus.req_valid = 1'b0;
    wait_resp(1, lat);
    chk("bp2_inst", bus.resp_inst, 32'h8687_8485);
    tick();

    // stall after byte 1 is captured
    accept(32'h0000_1000);
    tick(); tick();
    rdy = 1'b0;
    tick(); tick();
    chk("stall_mem_a", bus.mem_a, 32'h0000_1002);
    rdy = 1'b1;
    wait_resp(5, lat);
    chk("stall_lat",  lat, 32'd7);
    chk("stall_inst", bus.resp_inst, 32'h0010_0513);
    tick();

    // flush mid-fetch, then a fresh request
    accept(32'h0000_1000);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("flush_idle",  {31'd0, bus.req_ready},  32'd1);
    accept(32'h0000_2000);
    wait_resp(1, lat);
    chk("flush_lat",  lat, 32'd5);
    chk("flush_inst", bus.resp_inst, 32'h8687_8485);
    chk("flush_pc",   bus.resp_pc,   32'h0000_2000);
    tick();

    // flush in the acceptance cycle blocks the request
    flush = 1'b1;
    accept(32'h0000_1000);
    flush = 1'b0;
    chk("flush_acc", {31'd0, bus.req_ready}, 32'd1);
    tick();

    // address wrap
    accept(32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_mem_a", bus.mem_a, wrap_a[i]);
      tick();
    end
    chk("wrap_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("wrap_inst",  bus.resp_inst, 32'hA4A5_5A5B);
    chk("wrap_pc",    bus.resp_pc,   32'hFFFF_FFFE);
    tick();

    // asynchronous reset during fetch
    accept(32'h0000_1000);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("arst_mem_a", bus.mem_a, 32'h0);
    chk("arst_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    accept(32'h0000_2000);
    chk("arst_first_acc", {31'd0, bus.req_ready}, 32'd0);
    wait_resp(1, lat);
    chk("arst_inst", bus.resp_inst, 32'h8687_8485);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
